// File: rtl/sad_pe_array16.sv
// 16-lane SAD accumulator array feeding the min-SAD compare stage.
// Optional abort input enabled by defining SAD_PE_ARRAY_ABORT_EN.
module sad_pe_array16 #(
  parameter int PIX_W   = 8,
  parameter int SAD_W   = 22,
  parameter int BLK_PIX = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
`ifdef SAD_PE_ARRAY_ABORT_EN
  input  logic              abort,
`endif
  input  logic [PIX_W-1:0]  cur_pix,
  input  logic [16*PIX_W-1:0] ref_pix,
  output logic              busy,
  output logic              sad_valid,
  output logic [SAD_W-1:0]  sad_out0,
  output logic [SAD_W-1:0]  sad_out1,
  output logic [SAD_W-1:0]  sad_out2,
  output logic [SAD_W-1:0]  sad_out3,
  output logic [SAD_W-1:0]  sad_out4,
  output logic [SAD_W-1:0]  sad_out5,
  output logic [SAD_W-1:0]  sad_out6,
  output logic [SAD_W-1:0]  sad_out7,
  output logic [SAD_W-1:0]  sad_out8,
  output logic [SAD_W-1:0]  sad_out9,
  output logic [SAD_W-1:0]  sad_out10,
  output logic [SAD_W-1:0]  sad_out11,
  output logic [SAD_W-1:0]  sad_out12,
  output logic [SAD_W-1:0]  sad_out13,
  output logic [SAD_W-1:0]  sad_out14,
  output logic [SAD_W-1:0]  sad_out15,
  output logic              sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [15:0] LAST = 16'(BLK_PIX - 1);

  state_t           state, state_nxt;
  logic [15:0]      cnt;
  logic             sat;
  logic [SAD_W-1:0] acc     [16];
  logic [SAD_W-1:0] acc_nxt [16];
  logic [SAD_W-1:0] sad_r   [16];
  logic [15:0]      lane_sat;
  logic             abort_i;
  logic             clr, kill, take, last;

`ifdef SAD_PE_ARRAY_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign busy = (state == ACCUM);
  assign kill = busy && abort_i;
  assign clr  = (state != ACCUM) && start;
  assign take = busy && pix_valid && !abort_i;
  assign last = take && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM: begin
        if (kill)      state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-lane |cur-ref| at PIX_W+1 bits, summed with one carry bit for clamping
  for (genvar k = 0; k < 16; k++) begin : g_lane
    logic [PIX_W:0]   d;
    logic [PIX_W-1:0] mag;
    logic [SAD_W:0]   sum;
    assign d   = {1'b0, cur_pix} - {1'b0, ref_pix[k*PIX_W +: PIX_W]};
    assign mag = d[PIX_W] ? PIX_W'(~d + 1'b1) : d[PIX_W-1:0];
    assign sum = {1'b0, acc[k]} + (SAD_W+1)'(mag);
    assign lane_sat[k] = sum[SAD_W];
    assign acc_nxt[k]  = sum[SAD_W] ? {SAD_W{1'b1}} : sum[SAD_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sat       <= 1'b0;
      sad_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        acc[k]   <= '0;
        sad_r[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      sad_valid <= last;
      if (clr || kill) begin
        cnt <= '0;
        sat <= 1'b0;
        for (int k = 0; k < 16; k++) acc[k] <= '0;
      end else if (take) begin
        cnt <= cnt + 16'd1;
        sat <= sat | (|lane_sat);
        for (int k = 0; k < 16; k++) acc[k] <= acc_nxt[k];
        if (last) begin
          sat_flag <= sat | (|lane_sat);
          for (int k = 0; k < 16; k++) sad_r[k] <= acc_nxt[k];
        end
      end
    end
  end

  assign sad_out0  = sad_r[0];
  assign sad_out1  = sad_r[1];
  assign sad_out2  = sad_r[2];
  assign sad_out3  = sad_r[3];
  assign sad_out4  = sad_r[4];
  assign sad_out5  = sad_r[5];
  assign sad_out6  = sad_r[6];
  assign sad_out7  = sad_r[7];
  assign sad_out8  = sad_r[8];
  assign sad_out9  = sad_r[9];
  assign sad_out10 = sad_r[10];
  assign sad_out11 = sad_r[11];
  assign sad_out12 = sad_r[12];
  assign sad_out13 = sad_r[13];
  assign sad_out14 = sad_r[14];
  assign sad_out15 = sad_r[15];

endmodule

// File: tb/tb_sad_pe_array16.sv
// Bench for sad_pe_array16: default instance plus a SAD_W=10 instance
// sharing stimulus, checked against a true-sum model with clamping.
module tb_sad_pe_array16;

  logic         clk = 1'b0;
  logic         rst, start, pix_valid;
  logic         abort;
  logic [7:0]   cur_pix;
  logic [127:0] ref_pix;
  logic         busy_a, valid_a, sat_a;
  logic         busy_b, valid_b, sat_b;
  logic [21:0]  oa [16];
  logic [9:0]   ob [16];

  int checks = 0;
  int errors = 0;

  longint tsum   [16];
  longint held_a [16];
  longint held_b [16];
  bit     hs_a, hs_b;

  always #5 clk = ~clk;

  sad_pe_array16 u_a (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
`ifdef SAD_PE_ARRAY_ABORT_EN
    .abort(abort),
`endif
    .cur_pix(cur_pix), .ref_pix(ref_pix),
    .busy(busy_a), .sad_valid(valid_a),
    .sad_out0(oa[0]), .sad_out1(oa[1]), .sad_out2(oa[2]), .sad_out3(oa[3]),
    .sad_out4(oa[4]), .sad_out5(oa[5]), .sad_out6(oa[6]), .sad_out7(oa[7]),
    .sad_out8(oa[8]), .sad_out9(oa[9]), .sad_out10(oa[10]), .sad_out11(oa[11]),
    .sad_out12(oa[12]), .sad_out13(oa[13]), .sad_out14(oa[14]), .sad_out15(oa[15]),
    .sat_flag(sat_a)
  );

  sad_pe_array16 #(.SAD_W(10)) u_b (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
`ifdef SAD_PE_ARRAY_ABORT_EN
    .abort(abort),
`endif
    .cur_pix(cur_pix), .ref_pix(ref_pix),
    .busy(busy_b), .sad_valid(valid_b),
    .sad_out0(ob[0]), .sad_out1(ob[1]), .sad_out2(ob[2]), .sad_out3(ob[3]),
    .sad_out4(ob[4]), .sad_out5(ob[5]), .sad_out6(ob[6]), .sad_out7(ob[7]),
    .sad_out8(ob[8]), .sad_out9(ob[9]), .sad_out10(ob[10]), .sad_out11(ob[11]),
    .sad_out12(ob[12]), .sad_out13(ob[13]), .sad_out14(ob[14]), .sad_out15(ob[15]),
    .sat_flag(sat_b)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_a%0d", tag, k), 64'(oa[k]), 64'(held_a[k]));
      chk($sformatf("%s_b%0d", tag, k), 64'(ob[k]), 64'(held_b[k]));
    end
    chk({tag, "_sat_a"}, 64'(sat_a), 64'(hs_a));
    chk({tag, "_sat_b"}, 64'(sat_b), 64'(hs_b));
  endtask

  task automatic zero_held();
    for (int k = 0; k < 16; k++) begin
      held_a[k] = 0;
      held_b[k] = 0;
    end
    hs_a = 0;
    hs_b = 0;
  endtask

  task automatic drive(input int pat);
    int c, r, d;
    case (pat)
      0: c = 100;
      1: c = 0;
      2: c = 0;
      3: c = 10;
      default: c = int'($urandom_range(0, 255));
    endcase
    cur_pix = 8'(c);
    for (int k = 0; k < 16; k++) begin
      case (pat)
        0: r = 100 + k;
        1: r = 255;
        2: r = 0;
        3: r = 0;
        default: r = int'($urandom_range(0, 255));
      endcase
      ref_pix[k*8 +: 8] = 8'(r);
      d = c > r ? c - r : r - c;
      tsum[k] += d;
    end
  endtask

  // Runs one block; returns in the DONE cycle with results checked
  task automatic feed(input string tag, input int n, input int pat,
                      input bit gaps, input bit do_start,
                      input int start_at, input bit start_last);
    int busy_cnt = 0;
    bit early_valid = 0;
    if (do_start) begin
      start = 1;
      step();
      start = 0;
    end
    for (int k = 0; k < 16; k++) tsum[k] = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        busy_cnt += int'(busy_a);
        early_valid |= valid_a;
        pix_valid = 0;
        cur_pix = 8'($urandom);
        ref_pix = {$urandom, $urandom, $urandom, $urandom};
        step();
      end
      busy_cnt += int'(busy_a);
      early_valid |= valid_a;
      pix_valid = 1;
      start = (i == start_at) || (start_last && i == n - 1);
      drive(pat);
      step();
      start = 0;
    end
    pix_valid = 0;
    for (int k = 0; k < 16; k++) begin
      held_a[k] = tsum[k] > 4194303 ? 4194303 : tsum[k];
      held_b[k] = tsum[k] > 1023 ? 1023 : tsum[k];
    end
    hs_a = 0;
    hs_b = 0;
    for (int k = 0; k < 16; k++) begin
      if (tsum[k] > 4194303) hs_a = 1;
      if (tsum[k] > 1023) hs_b = 1;
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(gaps ? 2 * n : n));
    chk({tag, "_early_valid"}, 64'(early_valid), 64'd0);
    chk({tag, "_valid_a"}, 64'(valid_a), 64'd1);
    chk({tag, "_valid_b"}, 64'(valid_b), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy_a), 64'd0);
    check_out(tag);
  endtask

  task automatic to_idle(input string tag);
    step();
    chk({tag, "_strobe_end"}, 64'(valid_a), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    bit bad;
    rst = 1;
    start = 0;
    pix_valid = 0;
    abort = 0;
    cur_pix = 0;
    ref_pix = '0;
    zero_held();
    #3;
    check_out("reset");
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_valid", 64'(valid_a), 64'd0);
    step();
    rst = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'($urandom);
      cur_pix = 8'($urandom);
      step();
      bad |= valid_a | busy_a;
    end
    pix_valid = 0;
    chk("idle_quiet", 64'(bad), 64'd0);

    feed("ramp", 256, 0, 0, 1, -1, 0);
    chk("ramp_out15", 64'(oa[15]), 64'd3840);
    to_idle("ramp");

    feed("gaps", 256, 0, 1, 1, -1, 0);
    chk("gaps_out7", 64'(oa[7]), 64'd1792);
    to_idle("gaps");

    feed("clamp", 256, 1, 0, 1, -1, 0);
    chk("clamp_b0", 64'(ob[0]), 64'd1023);
    chk("clamp_satb", 64'(sat_b), 64'd1);
    to_idle("clamp");
    feed("zero", 256, 2, 0, 1, -1, 0);
    chk("zero_satb", 64'(sat_b), 64'd0);
    to_idle("zero");

    feed("b2b1", 256, 0, 0, 1, -1, 0);
    start = 1;
    step();
    start = 0;
    chk("b2b_valid", 64'(valid_a), 64'd0);
    chk("b2b_busy", 64'(busy_a), 64'd1);
    check_out("b2b_hold");
    feed("b2b2", 256, 3, 0, 0, 50, 0);
    chk("b2b2_out3", 64'(oa[3]), 64'd2560);
    to_idle("b2b2");

    feed("rand", 256, 4, 0, 1, 120, 1);
    to_idle("rand_startlast");
    feed("rand2", 256, 4, 1, 1, -1, 0);
    to_idle("rand2");

    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1;
      drive(4);
      step();
    end
    rst = 1;
    #1;
    zero_held();
    check_out("midrst");
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_valid", 64'(valid_a), 64'd0);
    #2;
    rst = 0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      bad |= valid_a | busy_a;
    end
    pix_valid = 0;
    chk("midrst_quiet", 64'(bad), 64'd0);

`ifdef SAD_PE_ARRAY_ABORT_EN
    feed("pre_abort", 256, 4, 0, 1, -1, 0);
    to_idle("pre_abort");
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1;
      drive(4);
      step();
    end
    abort = 1;
    step();
    abort = 0;
    pix_valid = 0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      bad |= valid_a | busy_a;
    end
    chk("abort_quiet", 64'(bad), 64'd0);
    check_out("abort_hold");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
